// File: rtl/fpu_pkg.sv
// Shared encodings for the FP add-class issue sequencer.
// Op codes, FSM states and the int/float conversion constant.
package fpu_pkg;

  localparam logic [1:0] FOP_FAD   = 2'd0;
  localparam logic [1:0] FOP_FSB   = 2'd1;
  localparam logic [1:0] FOP_FLT   = 2'd2;
  localparam logic [1:0] FOP_FLOOR = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // 2^23: aligns the integer part into the mantissa
  localparam logic [31:0] CONV_K_DFLT = 32'h4B00_0000;

  typedef struct packed {
    logic        u;
    logic        v;
    logic [31:0] x;
    logic [31:0] y;
  } fa_opnd_t;

endpackage

// File: rtl/fpu_op_decode.sv
// Maps an add-class op and its operands onto adder controls.
// Purely combinational; registered by the sequencer at accept.
import fpu_pkg::*;

module fpu_op_decode #(
  parameter logic [31:0] CONV_K = CONV_K_DFLT
) (
  input  logic [1:0]  i_op,
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  output logic        o_u,
  output logic        o_v,
  output logic [31:0] o_x,
  output logic [31:0] o_y
);

  always_comb begin
    o_u = 1'b0;
    o_v = 1'b0;
    o_x = i_x;
    o_y = i_y;
    unique case (i_op)
      FOP_FAD: ;
      FOP_FSB: o_y = {~i_y[31], i_y[30:0]};
      FOP_FLT: begin
        o_u = 1'b1;
        o_y = CONV_K;
      end
      FOP_FLOOR: begin
        o_v = 1'b1;
        o_y = CONV_K;
      end
    endcase
  end

endmodule

// File: rtl/fpu_add_sequencer.sv
// Issue/capture stage in front of the stalling pipelined FP adder.
// Holds adder inputs through RUN, captures z, with a stall watchdog.
import fpu_pkg::*;

module fpu_add_sequencer #(
  parameter int          MAX_CYC = 8,
  parameter logic [31:0] CONV_K  = CONV_K_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_z,
  output logic        rsp_err,
  output logic        fa_run,
  output logic        fa_u,
  output logic        fa_v,
  output logic [31:0] fa_x,
  output logic [31:0] fa_y,
  input  logic        fa_stall,
  input  logic [31:0] fa_z
);

  localparam int CW = $clog2(MAX_CYC + 1);

  logic [1:0]    r_state;
  fa_opnd_t      r_opnd;
  logic [31:0]   r_z;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  logic        w_run;
  logic        w_timeout;
  logic        w_u;
  logic        w_v;
  logic [31:0] w_x;
  logic [31:0] w_y;

  fpu_op_decode #(
    .CONV_K (CONV_K)
  ) u_dec (
    .i_op (req_op),
    .i_x  (req_x),
    .i_y  (req_y),
    .o_u  (w_u),
    .o_v  (w_v),
    .o_x  (w_x),
    .o_y  (w_y)
  );

  assign w_run     = (r_state == S_RUN);
  assign w_timeout = fa_stall && (r_cnt == CW'(MAX_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_opnd  <= '0;
      r_z     <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (ce) begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_opnd  <= '{u: w_u, v: w_v, x: w_x, y: w_y};
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!fa_stall) begin
            r_z     <= fa_z;
            r_err   <= 1'b0;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_z     <= '0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Adder inputs are forced to zero outside RUN
  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_z     = r_z;
  assign rsp_err   = r_err;
  assign fa_run    = w_run;
  assign fa_u      = w_run & r_opnd.u;
  assign fa_v      = w_run & r_opnd.v;
  assign fa_x      = w_run ? r_opnd.x : '0;
  assign fa_y      = w_run ? r_opnd.y : '0;

endmodule

// File: tb/tb_fpu_add_sequencer.sv
// Directed bench for fpu_add_sequencer with a behavioural adder
// and a response scoreboard queue.
module tb_fpu_add_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_x = '0;
  logic [31:0] req_y = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_z;
  logic        rsp_err;
  logic        fa_run;
  logic        fa_u;
  logic        fa_v;
  logic [31:0] fa_x;
  logic [31:0] fa_y;
  logic        fa_stall;
  logic [31:0] fa_z;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] z;
    logic        err;
  } exp_t;
  exp_t sb[$];

  logic stall_force = 1'b0;
  int   acnt = 0;

  fpu_add_sequencer #(
    .MAX_CYC (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_err   (rsp_err),
    .fa_run    (fa_run),
    .fa_u      (fa_u),
    .fa_v      (fa_v),
    .fa_x      (fa_x),
    .fa_y      (fa_y),
    .fa_stall  (fa_stall),
    .fa_z      (fa_z)
  );

  always #5 clk = ~clk;

  function automatic real sp2r(input logic [31:0] b);
    logic [63:0] d;
    int e;
    if (b[30:0] == 31'd0) return 0.0;
    e = int'(b[30:23]) - 127 + 1023;
    d = {b[31], e[10:0], b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] add_model(
    input logic u, input logic v,
    input logic [31:0] x, input logic [31:0] y);
    int fl;
    if (u) return r2sp(real'($signed(x)));
    if (v) begin
      fl = int'($floor(sp2r(x)));
      return 32'(fl);
    end
    return r2sp(sp2r(x) + sp2r(y));
  endfunction

  // Adder stalls three cycles with run high, then releases
  always @(posedge clk) begin
    if (!rst) acnt <= 0;
    else if (ce) acnt <= fa_run ? acnt + 1 : 0;
  end
  assign fa_stall = stall_force | (fa_run && acnt < 3);
  always_comb fa_z = add_model(fa_u, fa_v, fa_x, fa_y);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] x,
                       input logic [31:0] y);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_op = op;
    req_x = x;
    req_y = y;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 2'($urandom);
    req_x = $urandom;
    req_y = $urandom;
  endtask

  task automatic wait_rsp(input string tag, input logic eu, input logic ev,
                          input logic [31:0] ex, input logic [31:0] ey,
                          input int gap, input int elat);
    int lat = 1;
    int left = gap;
    logic bad = 1'b0;
    while (!rsp_valid && lat < 64) begin
      if (!fa_run || fa_u !== eu || fa_v !== ev ||
          fa_x !== ex || fa_y !== ey) bad = 1'b1;
      if (lat >= 2 && left > 0) begin
        ce = 1'b0;
        left--;
      end else ce = 1'b1;
      @(negedge clk);
      lat++;
    end
    ce = 1'b1;
    chk({tag, "_fa_hold"}, 32'(bad), 0);
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_fa_off"}, {29'd0, fa_run, fa_u, fa_v}, 0);
    chk({tag, "_fa_y_off"}, fa_y, 0);
  endtask

  task automatic pop_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 1);
      chk({tag, "_rsp_z"}, rsp_z, e.z);
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(e.err));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(rsp_valid), 0);
    chk({tag, "_err_clear"}, 32'(rsp_err), 0);
    chk({tag, "_ready_back"}, 32'(req_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic bad;
    #2 rst = 1'b0;
    #2;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rsp_z", rsp_z, 0);
    chk("rst_fa_ctl", {29'd0, fa_run, fa_u, fa_v}, 0);
    chk("rst_fa_x", fa_x, 0);
    chk("rst_fa_y", fa_y, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    issue(2'd0, 32'h3F80_0000, 32'h4000_0000);
    sb.push_back('{z: 32'h4040_0000, err: 1'b0});
    wait_rsp("fad", 1'b0, 1'b0, 32'h3F80_0000, 32'h4000_0000, 0, 5);
    pop_rsp("fad");

    issue(2'd1, 32'h4040_0000, 32'h3F80_0000);
    sb.push_back('{z: 32'h4000_0000, err: 1'b0});
    wait_rsp("fsb", 1'b0, 1'b0, 32'h4040_0000, 32'hBF80_0000, 0, 5);
    pop_rsp("fsb");

    issue(2'd2, 32'h0000_0007, 32'h1234_5678);
    sb.push_back('{z: 32'h40E0_0000, err: 1'b0});
    wait_rsp("flt", 1'b1, 1'b0, 32'h0000_0007, 32'h4B00_0000, 0, 5);
    pop_rsp("flt");

    issue(2'd3, 32'h4020_0000, 32'hDEAD_BEEF);
    sb.push_back('{z: 32'h0000_0002, err: 1'b0});
    wait_rsp("floor", 1'b0, 1'b1, 32'h4020_0000, 32'h4B00_0000, 0, 5);
    pop_rsp("floor");

    issue(2'd0, 32'h3F80_0000, 32'h4000_0000);
    sb.push_back('{z: 32'h4040_0000, err: 1'b0});
    wait_rsp("ce", 1'b0, 1'b0, 32'h3F80_0000, 32'h4000_0000, 3, 8);
    bad = 1'b0;
    req_valid = 1'b1;
    repeat (10) begin
      if (rsp_valid !== 1'b1 || rsp_z !== 32'h4040_0000 ||
          req_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bp_hold", 32'(bad), 0);
    pop_rsp("bp");

    stall_force = 1'b1;
    issue(2'd0, 32'h3F80_0000, 32'h4000_0000);
    sb.push_back('{z: 32'h0000_0000, err: 1'b1});
    wait_rsp("wdog", 1'b0, 1'b0, 32'h3F80_0000, 32'h4000_0000, 0, 9);
    stall_force = 1'b0;
    pop_rsp("wdog");

    issue(2'd0, 32'h3F80_0000, 32'h4000_0000);
    @(negedge clk);
    chk("abort_in_run", 32'(fa_run), 1);
    rst = 1'b0;
    #1;
    chk("abort_fa_run", 32'(fa_run), 0);
    chk("abort_req_ready", 32'(req_ready), 1);
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    rst = 1'b1;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
    end
    chk("abort_no_rsp", 32'(bad), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
